// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: shadow-pipeline entry
// layout and the youngest-producer search used by both operand paths.
package hazard_pkg;

  localparam logic [4:0] ZERO_REG   = 5'd31;
  localparam int         MAX_STAGES = 16;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } sb_entry_t;

  typedef sb_entry_t [MAX_STAGES-1:0] sb_vec_t;

  // Returns the 1-based index of the youngest producer of src, or 0 when none.
  // A producer never has rd == zero_reg, so a zero-register source never matches.
  function automatic int youngest_match(input sb_vec_t entries,
                                        input logic [4:0] src,
                                        input logic [4:0] zero_reg);
    int idx;
    idx = 0;
    for (int k = MAX_STAGES - 1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].we &&
          entries[k].rd != zero_reg && entries[k].rd == src)
        idx = k + 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sb_stage.sv
// One shadow-pipeline entry: loads its predecessor each enabled edge and can
// drop the valid bit on the same edge to squash wrong-path work.
module sb_stage
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      clr,
  input  sb_entry_t d,
  output sb_entry_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
      if (clr) q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight destinations in a STAGES-deep
// shadow pipeline and derives forwarding selects, load-use stalls and a stall count.
module hazard_scoreboard #(
  parameter int         STAGES      = 3,
  parameter int         LOAD_READY  = 2,
  parameter int         FLUSH_DEPTH = 1,
  parameter logic [4:0] ZERO_REG    = hazard_pkg::ZERO_REG,
  parameter int         COUNT_W     = 32,
  localparam int        SEL_W       = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  input  logic               issue_we,
  input  logic               issue_load,
  input  logic [4:0]         src_n,
  input  logic [4:0]         src_m,
  input  logic               use_n,
  input  logic               use_m,
  input  logic               flush,
  output logic               stall,
  output logic [SEL_W-1:0]   fwd_n,
  output logic [SEL_W-1:0]   fwd_m,
  output logic [COUNT_W-1:0] stall_count
);

  import hazard_pkg::*;

  if (LOAD_READY < 1 || LOAD_READY > STAGES) begin : g_bad_load_ready
    $error("hazard_scoreboard: LOAD_READY must lie in 1..STAGES");
  end
  if (FLUSH_DEPTH < 0 || FLUSH_DEPTH > STAGES) begin : g_bad_flush_depth
    $error("hazard_scoreboard: FLUSH_DEPTH must lie in 0..STAGES");
  end
  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("hazard_scoreboard: STAGES out of supported range");
  end

  sb_entry_t stage_q [STAGES];
  sb_entry_t issue_entry;
  sb_vec_t   vec;
  int        match_n;
  int        match_m;
  logic      load_n;
  logic      load_m;
  logic      haz_n;
  logic      haz_m;

  always_comb begin
    vec = '0;
    for (int k = 0; k < STAGES; k++) vec[k] = stage_q[k];
  end

  // A hazard exists only when the youngest producer is a load whose data
  // has not yet reached the first stage that can supply it.
  always_comb begin
    match_n = use_n ? youngest_match(vec, src_n, ZERO_REG) : 0;
    match_m = use_m ? youngest_match(vec, src_m, ZERO_REG) : 0;
    load_n  = 1'b0;
    load_m  = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (match_n == k + 1) load_n = stage_q[k].load;
      if (match_m == k + 1) load_m = stage_q[k].load;
    end
    haz_n = load_n && (match_n < LOAD_READY);
    haz_m = load_m && (match_m < LOAD_READY);
  end

  assign stall = issue_valid && !flush && (haz_n || haz_m);
  assign fwd_n = SEL_W'(match_n);
  assign fwd_m = SEL_W'(match_m);

  assign issue_entry = '{valid: issue_valid && !stall && !flush,
                         rd:    issue_rd,
                         we:    issue_we,
                         load:  issue_load};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sb_entry_t d;
    if (k == 0) begin : g_head
      assign d = issue_entry;
    end else begin : g_tail
      assign d = stage_q[k-1];
    end
    sb_stage u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .clr   (flush && (k < FLUSH_DEPTH)),
      .d     (d),
      .q     (stage_q[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && stall_count != {COUNT_W{1'b1}}) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_hazard_scoreboard;

  localparam int STAGES      = 3;
  localparam int LOAD_READY  = 2;
  localparam int FLUSH_DEPTH = 1;
  localparam int SEL_W       = 2;

  logic             clk         = 1'b0;
  logic             reset       = 1'b0;
  logic             issue_valid = 1'b0;
  logic [4:0]       issue_rd    = '0;
  logic             issue_we    = 1'b0;
  logic             issue_load  = 1'b0;
  logic [4:0]       src_n       = '0;
  logic [4:0]       src_m       = '0;
  logic             use_n       = 1'b0;
  logic             use_m       = 1'b0;
  logic             flush       = 1'b0;

  logic             stall;
  logic [SEL_W-1:0] fwd_n;
  logic [SEL_W-1:0] fwd_m;
  logic [31:0]      stall_count;

  logic             stall_s;
  logic [SEL_W-1:0] fwd_n_s;
  logic [SEL_W-1:0] fwd_m_s;
  logic [1:0]       count_s;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_load(issue_load), .src_n(src_n), .src_m(src_m),
    .use_n(use_n), .use_m(use_m), .flush(flush), .stall(stall),
    .fwd_n(fwd_n), .fwd_m(fwd_m), .stall_count(stall_count)
  );

  hazard_scoreboard #(.COUNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_load(issue_load), .src_n(src_n), .src_m(src_m),
    .use_n(use_n), .use_m(use_m), .flush(flush), .stall(stall_s),
    .fwd_n(fwd_n_s), .fwd_m(fwd_m_s), .stall_count(count_s)
  );

  // Reference model: a queue of in-flight instructions, youngest at the front.
  typedef struct {
    bit valid;
    int rd;
    bit we;
    bit load;
  } ent_t;

  ent_t   pipe[$];
  longint mcount;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void modelClear();
    pipe.delete();
    for (int i = 0; i < STAGES; i++) pipe.push_back('{0, 0, 0, 0});
    mcount = 0;
  endfunction

  function automatic int modelMatch(int src, bit use_it);
    if (!use_it || src == 31) return 0;
    for (int k = 0; k < pipe.size(); k++)
      if (pipe[k].valid && pipe[k].we && pipe[k].rd != 31 && pipe[k].rd == src)
        return k + 1;
    return 0;
  endfunction

  function automatic bit modelHazard(int src, bit use_it);
    int k;
    k = modelMatch(src, use_it);
    return (k != 0) && pipe[k-1].load && (k < LOAD_READY);
  endfunction

  function automatic bit modelStall();
    return issue_valid && !flush &&
           (modelHazard(int'(src_n), use_n) || modelHazard(int'(src_m), use_m));
  endfunction

  function automatic void modelStep();
    bit   st;
    ent_t e;
    st = modelStall();
    if (st) mcount++;
    e.valid = issue_valid && !st && !flush;
    e.rd    = int'(issue_rd);
    e.we    = issue_we;
    e.load  = issue_load;
    pipe.push_front(e);
    void'(pipe.pop_back());
    if (flush)
      for (int k = 0; k < FLUSH_DEPTH; k++) pipe[k].valid = 0;
  endfunction

  always @(posedge clk) begin
    if (!reset) modelClear();
    else        modelStep();
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    bit     es;
    longint esat;
    if (!reset) modelClear();
    es   = modelStall();
    esat = (mcount > 3) ? 3 : mcount;
    checkOutput("model_stall", 32'(stall), 32'(es));
    checkOutput("model_stall_sat", 32'(stall_s), 32'(es));
    if (!es) begin
      checkOutput("model_fwd_n", 32'(fwd_n), 32'(modelMatch(int'(src_n), use_n)));
      checkOutput("model_fwd_m", 32'(fwd_m), 32'(modelMatch(int'(src_m), use_m)));
      checkOutput("model_fwd_n_sat", 32'(fwd_n_s), 32'(modelMatch(int'(src_n), use_n)));
      checkOutput("model_fwd_m_sat", 32'(fwd_m_s), 32'(modelMatch(int'(src_m), use_m)));
    end
    checkOutput("model_count", stall_count, 32'(mcount));
    checkOutput("model_count_sat", 32'(count_s), 32'(esat));
  end

  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic we,
                               input logic ld, input logic [4:0] sn, input logic un,
                               input logic [4:0] sm, input logic um, input logic fl);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    issue_valid = v;
    issue_rd    = rd;
    issue_we    = we;
    issue_load  = ld;
    src_n       = sn;
    use_n       = un;
    src_m       = sm;
    use_m       = um;
    flush       = fl;
  endtask

  task automatic atSample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [4:0] pickReg();
    int r;
    r = int'($urandom_range(0, 8));
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  task automatic randomInputs();
    issue_valid = 1'($urandom_range(0, 3) != 0);
    issue_rd    = pickReg();
    issue_we    = 1'($urandom_range(0, 4) != 0);
    issue_load  = 1'($urandom_range(0, 2) == 0);
    src_n       = pickReg();
    src_m       = pickReg();
    use_n       = 1'($urandom_range(0, 3) != 0);
    use_m       = 1'($urandom_range(0, 3) != 0);
    flush       = 1'($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    // Reset held low with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      randomInputs();
      atSample();
      checkOutput("reset_stall", 32'(stall), 32'd0);
      checkOutput("reset_fwd_n", 32'(fwd_n), 32'd0);
      checkOutput("reset_fwd_m", 32'(fwd_m), 32'd0);
      checkOutput("reset_count", stall_count, 32'd0);
    end

    // ADD X1 then SUB X2,X1,X1: ALU forward from stage 1.
    applyStimulus(1, 5'd1, 1, 0, 5'd0, 0, 5'd0, 0, 0);
    applyStimulus(1, 5'd2, 1, 0, 5'd1, 1, 5'd1, 1, 0);
    atSample();
    checkOutput("alu_stall", 32'(stall), 32'd0);
    checkOutput("alu_fwd_n", 32'(fwd_n), 32'd1);
    checkOutput("alu_fwd_m", 32'(fwd_m), 32'd1);

    // LDUR X3 then ADD X4,X3,X5: one stall, then forward from stage 2.
    applyStimulus(1, 5'd3, 1, 1, 5'd0, 0, 5'd0, 0, 0);
    applyStimulus(1, 5'd4, 1, 0, 5'd3, 1, 5'd5, 1, 0);
    atSample();
    checkOutput("lu_stall_1", 32'(stall), 32'd1);
    checkOutput("lu_count_0", stall_count, 32'd0);
    applyStimulus(1, 5'd4, 1, 0, 5'd3, 1, 5'd5, 1, 0);
    atSample();
    checkOutput("lu_stall_2", 32'(stall), 32'd0);
    checkOutput("lu_fwd_n", 32'(fwd_n), 32'd2);
    checkOutput("lu_fwd_m", 32'(fwd_m), 32'd0);
    checkOutput("lu_count_1", stall_count, 32'd1);

    // ADD X6, ADD X6, ORR X7,X6,X6: youngest match wins.
    applyStimulus(1, 5'd6, 1, 0, 5'd0, 0, 5'd0, 0, 0);
    applyStimulus(1, 5'd6, 1, 0, 5'd0, 0, 5'd0, 0, 0);
    applyStimulus(1, 5'd7, 1, 0, 5'd6, 1, 5'd6, 1, 0);
    atSample();
    checkOutput("prio_fwd_n", 32'(fwd_n), 32'd1);
    checkOutput("prio_fwd_m", 32'(fwd_m), 32'd1);

    // XZR never forwards; an unused operand never forwards.
    applyStimulus(1, 5'd31, 1, 0, 5'd0, 0, 5'd0, 0, 0);
    applyStimulus(1, 5'd13, 1, 0, 5'd31, 1, 5'd31, 1, 0);
    atSample();
    checkOutput("xzr_fwd_n", 32'(fwd_n), 32'd0);
    checkOutput("xzr_fwd_m", 32'(fwd_m), 32'd0);
    applyStimulus(1, 5'd8, 1, 0, 5'd0, 0, 5'd0, 0, 0);
    applyStimulus(1, 5'd15, 1, 0, 5'd8, 1, 5'd8, 0, 0);
    atSample();
    checkOutput("unused_fwd_n", 32'(fwd_n), 32'd1);
    checkOutput("unused_fwd_m", 32'(fwd_m), 32'd0);

    // LDUR X9 then a dependent with flush: flush wins, bubble inserted.
    applyStimulus(1, 5'd9, 1, 1, 5'd0, 0, 5'd0, 0, 0);
    applyStimulus(1, 5'd10, 1, 0, 5'd9, 1, 5'd0, 0, 1);
    atSample();
    checkOutput("flush_stall", 32'(stall), 32'd0);
    checkOutput("flush_count", stall_count, 32'd1);
    applyStimulus(1, 5'd14, 1, 0, 5'd9, 1, 5'd10, 1, 0);
    atSample();
    checkOutput("post_flush_stall", 32'(stall), 32'd0);
    checkOutput("post_flush_fwd_n", 32'(fwd_n), 32'd2);
    checkOutput("bubble_fwd_m", 32'(fwd_m), 32'd0);
    checkOutput("post_flush_count", stall_count, 32'd1);

    // Randomised traffic with occasional mid-operation resets.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      reset = 1'($urandom_range(0, 99) != 0);
      randomInputs();
    end

    // Saturation of the 2-bit counter over five load-use events.
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 5'd11, 1, 1, 5'd0, 0, 5'd0, 0, 0);
      applyStimulus(1, 5'd12, 1, 0, 5'd11, 1, 5'd0, 0, 0);
      atSample();
      checkOutput("sat_stall", 32'(stall_s), 32'd1);
      applyStimulus(1, 5'd12, 1, 0, 5'd11, 1, 5'd0, 0, 0);
      atSample();
      checkOutput("sat_count", 32'(count_s), 32'(exp_sat[i]));
      checkOutput("sat_full_count", stall_count, 32'(i + 1));
    end

    applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined LEGv8 core. Tracks destination registers of in-flight instructions in a STAGES-deep shadow pipeline. From that it generates per-operand forwarding selects, load-use stalls and flush-driven bubble insertion. It also keeps a saturating stall counter. It sits beside the register-fetch stage and replaces the fixed two-stage Rd comparators with a single unit that handles any pipeline depth and load latency.

## Interface
- STAGES, 3: tracked stages after issue (1 = EX, 2 = MEM, …, STAGES = WB).
- LOAD_READY, 2: first stage whose output carries load data; must be 1..STAGES.
- FLUSH_DEPTH, 1: youngest stages cleared by flush; must be 0..STAGES.
- ZERO_REG, 31: register that never creates a hazard (XZR).
- COUNT_W, 32: stall counter width.
- SEL_W, $clog2(STAGES+1): derived forwarding-select width.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  an instruction in register fetch requests issue.
- issue_rd  in  5  its destination register.
- issue_we  in  1  it writes issue_rd.
- issue_load  in  1  it is a load (LDUR).
- src_n, src_m  in  5 each  source registers Rn and Rm.
- use_n, use_m  in  1 each  the corresponding source is actually read.
- flush  in  1  a taken branch resolved this cycle.
- stall  out  1  hold PC and the fetch/RF pipeline registers this cycle.
- fwd_n, fwd_m  out  SEL_W each  0 = register file; k = forward from stage k output.
- stall_count  out  COUNT_W  number of stalled cycles, saturating.

## Operation
- Each stage k holds {valid, rd, we, load}. An entry is a producer when valid && we && rd != ZERO_REG.
- For each source with use_x=1 and src_x != ZERO_REG:
  - Find the youngest stage (smallest k) whose producer rd == src_x.
  - fwd_x = k if one exists, otherwise fwd_x = 0.
  - If use_x=0 or src_x == ZERO_REG, fwd_x = 0.
- Hazard condition: a matched producer has load=1 and k < LOAD_READY.
- stall = issue_valid && !flush && hazard on either source.
- While stall=1, fwd outputs are don't-care. Bench checks them only when stall=0.
- Shadow pipeline advances on every edge. Stage k+1 takes the contents of stage k, and the entry leaving stage STAGES is discarded.
- Stage 1 loads the issue fields when issue_valid && !stall && !flush. Otherwise stage 1 loads a bubble (valid=0).
- Flush sets valid=0 in stages 1..FLUSH_DEPTH on the same edge, after the shift. This clears the wrong-path instructions. Older stages still advance normally.
- stall_count increments on every edge where stall=1 and holds at all-ones once it saturates.

## Timing
- On reset low: every stage valid=0, stall_count=0, stall=0, fwd_n=fwd_m=0. Reset takes effect immediately and asynchronously.
- Mid-operation reset discards all in-flight entries. The first cycle after release behaves as an empty pipeline.
- stall and fwd are combinational from the inputs and stage state within the same cycle. There is no registered output except stall_count.
- A load followed by a dependent instruction stalls for LOAD_READY-1 cycles, then forwards from stage LOAD_READY. With the defaults this is one stall cycle, then fwd=2.
- ALU results forward from stage 1 with zero stall.
- If flush and stall would both be active, flush wins: stall=0 and a bubble is inserted.
- If a producer matches both sources, both fwd outputs select that stage independently.
- Producers in stage STAGES forward as stage STAGES, which covers register-file write/read in the same cycle.

## Structure
- Package hazard_pkg:
  - typedef sb_entry_t {valid, rd[4:0], we, load}.
  - ZERO_REG constant.
  - function youngest_match(entries, src) that returns the stage index.
- One sub-module, sb_stage: a single entry register with async active-low reset, load enable and clear. It is instantiated STAGES times in a generate loop.
- Elaboration-time assertions on the LOAD_READY and FLUSH_DEPTH ranges.

## Test plan
- Reset: hold reset=0 with random inputs. Expect stall=0, fwd=0, stall_count=0. Release reset and issue ADD X1 then SUB X2,X1,X1. Expect fwd_n=fwd_m=1 and no stall.
- Load-use: issue LDUR X3, then ADD X4,X3,X5. Expect stall=1 for one cycle, then fwd_n=2 and fwd_m=0 with stall=0. stall_count=1.
- Priority: issue ADD X6, ADD X6, then ORR X7,X6,X6. Expect fwd_n=fwd_m=1, the youngest match.
- XZR and unused operands: issue ADD X31, then a reader of X31. Expect fwd=0. Issue ADD X8 followed by a reader with src_m=8 and use_m=0. Expect fwd_m=0.
- Flush during stall: issue LDUR X9, then a dependent instruction with flush=1 in the same cycle. Expect stall=0, a bubble in stage 1 and stall_count unchanged.
- Saturation: override COUNT_W=2 and force 5 consecutive load-use stalls. Expect stall_count sequence 1,2,3,3,3.
